spinner_quad_decoder: RTL and testbench



---
 rtl/spinner_pkg.sv | 41 ++++
 rtl/spinner_quad_decoder_filter.sv | 66 ++++++
 rtl/spinner_quad_decoder.sv | 177 +++++++++++++++++
 tb/tb_spinner_quad_decoder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spinner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : spinner_pkg                                                  |
// | Description : Shared definitions for quadrature spinner decode/encode:     |
// |               idle AB level, step codes, count type and the gray-code      |
// |               step classifier used by both the decoder and the emulator.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package spinner_pkg;

  // Both phases high is the rest level of the AB pair.
  localparam logic [1:0] AB_IDLE = 2'b11;

  // Default count width and the matching signed count type.
  localparam int CNT_W_DEF = 12;
  typedef logic signed [CNT_W_DEF-1:0] count_t;

  // Signed 2-bit step classification. The otherwise unused -2 code
  // marks a double-bit jump whose direction cannot be known.
  typedef logic signed [1:0] qstep_t;
  localparam qstep_t QS_NONE    = 2'sb00;
  localparam qstep_t QS_POS     = 2'sb01;
  localparam qstep_t QS_NEG     = 2'sb11;
  localparam qstep_t QS_ILLEGAL = 2'sb10;

  // Classify one AB transition.
  // Positive rotation walks 11 -> 01 -> 00 -> 10 -> 11.
  function automatic qstep_t quad_step(input logic [1:0] prev, input logic [1:0] next);
    qstep_t r;
    r = QS_NONE;
    case ({prev, next})
      4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: r = QS_POS;
      4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: r = QS_NEG;
      4'b11_00, 4'b00_11, 4'b01_10, 4'b10_01: r = QS_ILLEGAL;
      default:                                r = QS_NONE;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spinner_quad_decoder_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : quad_glitch_filter                                           |
// | Description : Two-flop synchroniser for the raw AB pair followed by a      |
// |               stability filter. A new AB value must be seen on FILT_LEN    |
// |               consecutive ce samples before it is offered for decode.      |
// | Ports       : clk, rst           clock, synchronous active-high reset      |
// |               i_ce               sample enable for the filter              |
// |               i_ab_raw[1:0]      asynchronous {A,B} from the encoder       |
// |               i_ab_accepted[1:0] AB value currently held by the decoder    |
// |               o_ab_stable[1:0]   filtered candidate value                  |
// |               o_stable_pulse     candidate ready to be accepted this cycle |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module quad_glitch_filter
  import spinner_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ce,
  input  logic [1:0] i_ab_raw,
  input  logic [1:0] i_ab_accepted,
  output logic [1:0] o_ab_stable,
  output logic       o_stable_pulse
);

  localparam int             C_CW      = 4;
  localparam logic [C_CW-1:0] C_CNT_MAX = '1;
  localparam logic [C_CW-1:0] C_CNT_HIT = C_CW'(FILT_LEN - 1);

  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_cand;
  logic [C_CW-1:0] r_cnt;

  // The synchroniser runs every clock; only the filter honours ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= AB_IDLE;
      r_sync2 <= AB_IDLE;
      r_cand  <= AB_IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_ab_raw;
      r_sync2 <= r_sync1;
      if (i_ce) begin
        if (r_sync2 != r_cand) begin
          r_cand <= r_sync2;
          r_cnt  <= '0;
        end else if (r_cnt != C_CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_ab_stable = r_cand;

  // The counter only passes through FILT_LEN-1 once per candidate, and the
  // decoder adopts the candidate on that cycle, so this fires once per change.
  assign o_stable_pulse = i_ce && (r_cnt == C_CNT_HIT) && (r_cand != i_ab_accepted);

endmodule
`default_nettype wire

// File: rtl/spinner_quad_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spinner_quad_decoder                                         |
// | Description : AB quadrature decoder: filtered gray-code step decode,       |
// |               optional rate division, saturating read-and-clear delta and  |
// |               free-running wrap-around position.                           |
// | Ports       : clk_12m, reset   clock, synchronous active-high reset        |
// |               ce               sample enable for filter/decode             |
// |               enc_a, enc_b     asynchronous encoder phases                 |
// |               rd               read-and-clear strobe for delta             |
// |               rd_data          signed delta snapshot (held until next rd)  |
// |               rd_valid         pulse, cycle after rd                       |
// |               step, dir        pulse per output count, its direction       |
// |               illegal          pulse on a double-bit AB jump               |
// |               position         wrap-around sum of output counts            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module spinner_quad_decoder
  import spinner_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int DIV      = 2,
  parameter int CNT_W    = 12
) (
  input  logic                    clk_12m,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    rd,
  output logic signed [CNT_W-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    step,
  output logic                    dir,
  output logic                    illegal,
  output logic [CNT_W-1:0]        position
);

  // Sub-count holds -(DIV-1)..+(DIV-1); three signed bits cover DIV up to 4.
  localparam logic signed [2:0]       C_SUB_MAX = 3'(DIV - 1);
  localparam logic signed [2:0]       C_SUB_MIN = -C_SUB_MAX;
  localparam logic signed [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic signed [CNT_W-1:0] C_DMAX    = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] C_DMIN    = -C_DMAX;
  localparam logic [CNT_W-1:0]        C_POS_ONE = CNT_W'(1);

  logic [1:0]              w_ab_stable;
  logic                    w_stable;
  qstep_t                  w_qs;
  logic                    w_edge_pos;
  logic                    w_edge_neg;
  logic                    w_ill;
  logic signed [2:0]       w_sub_next;
  logic                    w_cnt_pos;
  logic                    w_cnt_neg;
  logic signed [CNT_W-1:0] w_delta_acc;
  logic signed [CNT_W-1:0] w_delta_next;

  logic [1:0]              r_acc;
  logic                    r_primed;
  logic signed [2:0]       r_sub;
  logic signed [CNT_W-1:0] r_delta;
  logic signed [CNT_W-1:0] r_rd_data;
  logic                    r_rd_valid;
  logic                    r_step;
  logic                    r_dir;
  logic                    r_illegal;
  logic [CNT_W-1:0]        r_position;

  quad_glitch_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk            (clk_12m),
    .rst            (reset),
    .i_ce           (ce),
    .i_ab_raw       ({enc_a, enc_b}),
    .i_ab_accepted  (r_acc),
    .o_ab_stable    (w_ab_stable),
    .o_stable_pulse (w_stable)
  );

  // Until primed the accepted state is only a reset guess, so the first
  // stable value is adopted without being interpreted as motion.
  assign w_qs       = quad_step(r_acc, w_ab_stable);
  assign w_edge_pos = w_stable && r_primed && (w_qs == QS_POS);
  assign w_edge_neg = w_stable && r_primed && (w_qs == QS_NEG);
  assign w_ill      = w_stable && r_primed && (w_qs == QS_ILLEGAL);

  // Prescaler: opposite edges walk the sub-count back, so a reversal
  // cancels partial progress instead of producing a count.
  always_comb begin
    w_sub_next = r_sub;
    w_cnt_pos  = 1'b0;
    w_cnt_neg  = 1'b0;
    if (w_edge_pos) begin
      if (r_sub == C_SUB_MAX) begin
        w_cnt_pos  = 1'b1;
        w_sub_next = '0;
      end else begin
        w_sub_next = r_sub + 3'sd1;
      end
    end else if (w_edge_neg) begin
      if (r_sub == C_SUB_MIN) begin
        w_cnt_neg  = 1'b1;
        w_sub_next = '0;
      end else begin
        w_sub_next = r_sub - 3'sd1;
      end
    end
  end

  // Delta saturates symmetrically; a read restarts it from this cycle's
  // count so motion coinciding with the read is carried forward.
  always_comb begin
    w_delta_acc = r_delta;
    if (w_cnt_pos && (r_delta != C_DMAX)) begin
      w_delta_acc = r_delta + C_ONE;
    end else if (w_cnt_neg && (r_delta != C_DMIN)) begin
      w_delta_acc = r_delta - C_ONE;
    end
    w_delta_next = w_delta_acc;
    if (rd) begin
      if (w_cnt_pos) begin
        w_delta_next = C_ONE;
      end else if (w_cnt_neg) begin
        w_delta_next = -C_ONE;
      end else begin
        w_delta_next = '0;
      end
    end
  end

  always_ff @(posedge clk_12m) begin
    if (reset) begin
      r_acc      <= AB_IDLE;
      r_primed   <= 1'b0;
      r_sub      <= '0;
      r_delta    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_illegal  <= 1'b0;
      r_position <= '0;
    end else begin
      r_rd_valid <= rd;
      if (rd) begin
        r_rd_data <= r_delta;
      end
      r_delta   <= w_delta_next;
      r_sub     <= w_sub_next;
      r_step    <= w_cnt_pos | w_cnt_neg;
      r_illegal <= w_ill;
      if (w_cnt_pos | w_cnt_neg) begin
        r_dir <= w_cnt_pos;
      end
      if (w_cnt_pos) begin
        r_position <= r_position + C_POS_ONE;
      end else if (w_cnt_neg) begin
        r_position <= r_position - C_POS_ONE;
      end
      if (w_stable) begin
        r_acc    <= w_ab_stable;
        r_primed <= 1'b1;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign step     = r_step;
  assign dir      = r_dir;
  assign illegal  = r_illegal;
  assign position = r_position;

endmodule
`default_nettype wire

// File: tb/tb_spinner_quad_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spinner_quad_decoder                                      |
// | Description : Self-checking bench. Two decoders (DIV=1 and DIV=2) share    |
// |               stimulus; a cycle reference model built from gray-position   |
// |               arithmetic checks every output, alongside a vector table     |
// |               and hand-written read/saturation sequences.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_spinner_quad_decoder;

  localparam int FILT = 4;
  localparam int CW   = 12;
  localparam int SATV = 2047;

  logic clk = 1'b0;
  logic reset, ce, enc_a, enc_b, rd;
  logic signed [CW-1:0] rd_data1, rd_data2;
  logic rd_valid1, step1, dir1, illegal1;
  logic rd_valid2, step2, dir2, illegal2;
  logic [CW-1:0] position1, position2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  spinner_quad_decoder #(.FILT_LEN(FILT), .DIV(1), .CNT_W(CW)) u_dut_d1 (
    .clk_12m(clk), .reset(reset), .ce(ce), .enc_a(enc_a), .enc_b(enc_b), .rd(rd),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .step(step1), .dir(dir1),
    .illegal(illegal1), .position(position1));

  spinner_quad_decoder #(.FILT_LEN(FILT), .DIV(2), .CNT_W(CW)) u_dut_d2 (
    .clk_12m(clk), .reset(reset), .ce(ce), .enc_a(enc_a), .enc_b(enc_b), .rd(rd),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .step(step2), .dir(dir2),
    .illegal(illegal2), .position(position2));

  // ---------------- reference model ----------------
  // Index 0 models the DIV=1 instance, index 1 the DIV=2 instance.
  int m_div[2] = '{1, 2};
  logic [1:0] m_s1 = 2'b11, m_s2 = 2'b11, m_runval = 2'b11, m_acc = 2'b11;
  int m_run = 1, m_primed = 0, m_ill = 0;
  int m_sub[2] = '{0, 0};
  int m_delta[2] = '{0, 0};
  int m_pos[2] = '{0, 0};
  int m_rd_data[2] = '{0, 0};
  int m_rd_valid[2] = '{0, 0};
  int m_step[2] = '{0, 0};
  int m_dir[2] = '{0, 0};

  // Position of an AB value along the positive rotation 11,01,00,10.
  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] s2_old;
    int d, c;
    bit acc_now;
    if (reset) begin
      m_s1 = 2'b11; m_s2 = 2'b11; m_runval = 2'b11; m_acc = 2'b11;
      m_run = 1; m_primed = 0; m_ill = 0;
      for (int k = 0; k < 2; k++) begin
        m_sub[k] = 0; m_delta[k] = 0; m_pos[k] = 0; m_rd_data[k] = 0;
        m_rd_valid[k] = 0; m_step[k] = 0; m_dir[k] = 0;
      end
    end else begin
      s2_old = m_s2;
      m_s2 = m_s1;
      m_s1 = {enc_a, enc_b};
      m_ill = 0;
      d = 0;
      acc_now = 0;
      if (ce) begin
        // m_run = number of consecutive ce samples of m_runval so far
        acc_now = (m_run == FILT) && (m_runval != m_acc);
        if (acc_now) begin
          if (m_primed == 0) begin
            m_primed = 1;
          end else begin
            d = (gidx(m_runval) - gidx(m_acc) + 4) % 4;
            if (d == 2) m_ill = 1;
          end
          m_acc = m_runval;
        end
        if (s2_old != m_runval) begin
          m_runval = s2_old;
          m_run = 1;
        end else if (m_run < 1000) begin
          m_run++;
        end
      end
      for (int k = 0; k < 2; k++) begin
        c = 0;
        if (acc_now && d == 1) begin
          m_sub[k]++;
          if (m_sub[k] == m_div[k]) begin c = 1; m_sub[k] = 0; end
        end else if (acc_now && d == 3) begin
          m_sub[k]--;
          if (m_sub[k] == -m_div[k]) begin c = -1; m_sub[k] = 0; end
        end
        m_rd_valid[k] = rd ? 1 : 0;
        if (rd) begin
          m_rd_data[k] = m_delta[k];
          m_delta[k] = c;
        end else begin
          m_delta[k] = m_delta[k] + c;
          if (m_delta[k] > SATV) m_delta[k] = SATV;
          if (m_delta[k] < -SATV) m_delta[k] = -SATV;
        end
        m_step[k] = (c != 0) ? 1 : 0;
        if (c != 0) m_dir[k] = (c > 0) ? 1 : 0;
        m_pos[k] = (m_pos[k] + c + 4096) % 4096;
      end
    end
  end

  task automatic check_dut(input int k, input int g_rdd, input int g_rdv, input int g_step,
                           input int g_dir, input int g_ill, input int g_pos);
    checks++;
    if (g_rdd != m_rd_data[k] || g_rdv != m_rd_valid[k] || g_step != m_step[k] ||
        g_dir != m_dir[k] || g_ill != m_ill || g_pos != m_pos[k]) begin
      errors++;
      $display("FAIL model_div%0d t=%0t got rdd=%0d rdv=%0d step=%0d dir=%0d ill=%0d pos=%0d exp rdd=%0d rdv=%0d step=%0d dir=%0d ill=%0d pos=%0d",
               m_div[k], $time, g_rdd, g_rdv, g_step, g_dir, g_ill, g_pos,
               m_rd_data[k], m_rd_valid[k], m_step[k], m_dir[k], m_ill, m_pos[k]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, rd_data1, rd_valid1, step1, dir1, illegal1, position1);
      check_dut(1, rd_data2, rd_valid2, step2, dir2, illegal2, position2);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] ab;
    int hold;
    int pos1;
    int pos2;
    int steps2;
    int ills;
  } vec_t;

  vec_t vt[18];

  task automatic run_vec(input int i);
    int n_step2, n_ill;
    n_step2 = 0;
    n_ill = 0;
    {enc_a, enc_b} = vt[i].ab;
    for (int c = 0; c < vt[i].hold; c++) begin
      @(negedge clk);
      n_step2 += step2;
      n_ill += illegal1;
    end
    chk($sformatf("vec%0d_pos1", i), position1, vt[i].pos1);
    chk($sformatf("vec%0d_pos2", i), position2, vt[i].pos2);
    chk($sformatf("vec%0d_steps2", i), n_step2, vt[i].steps2);
    chk($sformatf("vec%0d_illegal", i), n_ill, vt[i].ills);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_edges(input int n, input bit positive, input int hold);
    logic [1:0] seqp[4];
    logic [1:0] seqn[4];
    seqp = '{2'b01, 2'b00, 2'b10, 2'b11};
    seqn = '{2'b10, 2'b00, 2'b01, 2'b11};
    for (int e = 0; e < n; e++) begin
      {enc_a, enc_b} = positive ? seqp[e % 4] : seqn[e % 4];
      repeat (hold) @(negedge clk);
    end
  endtask

  task automatic read_pulse();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    logic [1:0] cur;
    reset = 1'b1; ce = 1'b1; rd = 1'b0; {enc_a, enc_b} = 2'b11;
    vt[0]  = '{2'b00, 10, 0, 0, 0, 0};
    vt[1]  = '{2'b11,  8, 0, 0, 0, 1};
    vt[2]  = '{2'b01,  8, 1, 0, 0, 0};
    vt[3]  = '{2'b00,  8, 2, 1, 1, 0};
    vt[4]  = '{2'b10,  8, 3, 1, 0, 0};
    vt[5]  = '{2'b11,  8, 4, 2, 1, 0};
    vt[6]  = '{2'b10,  8, 3, 2, 0, 0};
    vt[7]  = '{2'b11,  8, 4, 2, 0, 0};
    vt[8]  = '{2'b10,  8, 3, 2, 0, 0};
    vt[9]  = '{2'b00,  8, 2, 1, 1, 0};
    vt[10] = '{2'b10,  8, 3, 1, 0, 0};
    vt[11] = '{2'b11,  8, 4, 2, 1, 0};
    vt[12] = '{2'b01,  2, 4, 2, 0, 0};
    vt[13] = '{2'b11,  6, 4, 2, 0, 0};
    vt[14] = '{2'b01,  3, 4, 2, 0, 0};
    vt[15] = '{2'b11,  8, 4, 2, 0, 0};
    vt[16] = '{2'b00,  8, 4, 2, 0, 1};
    vt[17] = '{2'b10,  8, 5, 2, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_rd_data1", rd_data1, 0);   chk("rst_rd_data2", rd_data2, 0);
    chk("rst_rd_valid1", rd_valid1, 0); chk("rst_rd_valid2", rd_valid2, 0);
    chk("rst_step1", step1, 0);         chk("rst_step2", step2, 0);
    chk("rst_dir1", dir1, 0);           chk("rst_dir2", dir2, 0);
    chk("rst_illegal1", illegal1, 0);   chk("rst_illegal2", illegal2, 0);
    chk("rst_position1", position1, 0); chk("rst_position2", position2, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Priming, one full positive cycle, then back-to-back reads.
    for (int i = 0; i <= 5; i++) run_vec(i);
    rd = 1'b1;
    @(negedge clk);
    chk("rd1_valid", rd_valid1, 1);
    chk("rd1_data_div1", rd_data1, 4);
    chk("rd1_data_div2", rd_data2, 2);
    @(negedge clk);
    rd = 1'b0;
    chk("rd2_valid", rd_valid2, 1);
    chk("rd2_data_div1", rd_data1, 0);
    chk("rd2_data_div2", rd_data2, 0);

    // Reversals, glitches and a double-bit jump.
    for (int i = 6; i <= 17; i++) run_vec(i);

    // Read landing on the same cycle as an output count.
    read_pulse();
    repeat (2) @(negedge clk);
    {enc_a, enc_b} = 2'b11;
    repeat (6) @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk("rdstep_step1", step1, 1);
    chk("rdstep_step2", step2, 1);
    chk("rdstep_data1", rd_data1, 0);
    chk("rdstep_data2", rd_data2, 0);
    read_pulse();
    chk("rdstep_next1", rd_data1, 1);
    chk("rdstep_next2", rd_data2, 1);

    // Saturation in both directions.
    do_reset();
    {enc_a, enc_b} = 2'b00; repeat (10) @(negedge clk);
    {enc_a, enc_b} = 2'b11; repeat (8) @(negedge clk);
    drive_edges(2100, 1'b1, 5);
    repeat (12) @(negedge clk);
    read_pulse();
    chk("satp_data1", rd_data1, 2047);
    chk("satp_data2", rd_data2, 1050);
    chk("satp_pos1", position1, 2100);
    chk("satp_pos2", position2, 1050);
    drive_edges(2100, 1'b0, 5);
    repeat (12) @(negedge clk);
    read_pulse();
    chk("satn_data1", rd_data1, -2047);
    chk("satn_data2", rd_data2, -1050);
    chk("satn_pos1", position1, 0);
    chk("satn_pos2", position2, 0);

    // Randomised motion, ce gaps, reads and one mid-run reset.
    do_reset();
    cur = 2'b11;
    for (int it = 0; it < 400; it++) begin
      int r, h;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        cur = ($urandom_range(0, 1) == 1) ? {cur[1] ^ cur[0] ^ 1'b1 ? ~cur[1] : cur[1], cur[1] ^ cur[0] ^ 1'b1 ? cur[0] : ~cur[0]} : {cur[1] ^ cur[0] ^ 1'b1 ? cur[1] : ~cur[1], cur[1] ^ cur[0] ^ 1'b1 ? ~cur[0] : cur[0]};
      end else if (r < 8) begin
        cur = ~cur;
      end else begin
        cur = 2'($urandom_range(0, 3));
      end
      {enc_a, enc_b} = cur;
      h = $urandom_range(1, 9);
      for (int c = 0; c < h; c++) begin
        ce = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 9) == 0);
        @(negedge clk);
      end
      if (it == 200) begin
        ce = 1'b1;
        rd = 1'b0;
        do_reset();
      end
    end
    ce = 1'b1;
    rd = 1'b0;
    repeat (12) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
